// File: rtl/wdt_irq_ctrl_pkg.sv
// wdt_irq_pkg: shared register map, controller states and source IDs for the interrupt controller
package wdt_irq_pkg;

    typedef enum logic [1:0] {
        ADDR_PENDING = 2'd0,
        ADDR_ENABLE  = 2'd1,
        ADDR_CLAIM   = 2'd2,
        ADDR_MODE    = 2'd3
    } addr_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int SRC_WDT = 1;
    localparam int SRC_DMA = 2;

endpackage

// File: rtl/wdt_irq_ctrl_if.sv
// wdt_irq_ctrl_if: CPU register port and interrupt line of the controller
//   reg_wen/reg_ren/reg_addr/reg_wdata : CPU -> controller access strobes
//   reg_rdata/reg_rvalid               : read response, one cycle after reg_ren
//   ext_irq                            : registered interrupt request to the CPU
interface wdt_irq_ctrl_if;

    logic        reg_wen;
    logic        reg_ren;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        ext_irq;

    modport master (
        output reg_wen, reg_ren, reg_addr, reg_wdata,
        input  reg_rdata, reg_rvalid, ext_irq
    );

    modport slave (
        input  reg_wen, reg_ren, reg_addr, reg_wdata,
        output reg_rdata, reg_rvalid, ext_irq
    );

endinterface

// File: rtl/wdt_irq_ctrl_irq_gateway.sv
// irq_gateway: per-source request latch with level/edge qualification and in-flight blocking
//   clk, rst (sync, active low)
//   src      : synchronized interrupt level
//   mode     : 1 = edge, 0 = level
//   claim    : source is being claimed this cycle
//   complete : claimed source is being completed this cycle
//   pending, in_flight : gateway state
module irq_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_flight
);

    logic src_q;
    logic set;

    // requests arriving while the source is being serviced are dropped, not queued
    assign set = ~in_flight & (mode ? src & ~src_q : src);

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q     <= 1'b0;
            pending   <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            src_q     <= src;
            pending   <= claim ? 1'b0 : (set | pending);
            in_flight <= claim | (in_flight & ~complete);
        end
    end

endmodule

// File: rtl/wdt_irq_ctrl.sv
// wdt_irq_ctrl: fixed-priority interrupt controller with claim/complete register port
//   clk, rst (sync, active low)
//   src_irq : synchronized interrupt levels, bit i-1 is source ID i (ID 1 = WDT, ID 2 = DMA)
//   bus     : register port (PENDING/ENABLE/CLAIM/MODE) and ext_irq
module wdt_irq_ctrl
    import wdt_irq_pkg::*;
#(
    parameter int N_SRC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    wdt_irq_ctrl_if.slave    bus
);

    localparam int ID_W = $clog2(N_SRC + 1);

    addr_e            addr;
    state_t           state;
    state_t           state_nx;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] in_flight;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] req;
    logic [ID_W-1:0]  claim_id;
    logic [ID_W-1:0]  cur_id;
    logic [31:0]      rdata_nx;
    logic             claim_fire;
    logic             complete_fire;
    logic             unused_wdata;

    assign addr         = addr_e'(bus.reg_addr);
    assign req          = pending & enable;
    assign unused_wdata = ^bus.reg_wdata[31:N_SRC];

    // lowest-numbered requesting source wins; 0 means nothing to claim
    always_comb begin
        claim_id = '0;
        for (int k = N_SRC; k >= 1; k--)
            if (req[k-1]) claim_id = ID_W'(k);
    end

    // a simultaneous write turns the read into a side-effect-free dummy
    assign claim_fire    = bus.reg_ren && !bus.reg_wen && addr == ADDR_CLAIM && state == IDLE && claim_id != '0;
    assign complete_fire = bus.reg_wen && addr == ADDR_CLAIM && state == BUSY && bus.reg_wdata[ID_W-1:0] == cur_id;

    genvar i;
    generate
        for (i = 0; i < N_SRC; i++) begin : g_src
            irq_gateway u_gw (
                .clk       (clk),
                .rst       (rst),
                .src       (src_irq[i]),
                .mode      (mode[i]),
                .claim     (claim_fire && claim_id == ID_W'(i + 1)),
                .complete  (complete_fire && cur_id == ID_W'(i + 1)),
                .pending   (pending[i]),
                .in_flight (in_flight[i])
            );
        end
    endgenerate

    always_comb begin
        state_nx = claim_fire ? BUSY : complete_fire ? IDLE : state;
    end

    always_comb begin
        rdata_nx = bus.reg_wen              ? 32'd0 :
                   addr == ADDR_PENDING     ? 32'(pending) :
                   addr == ADDR_ENABLE      ? 32'(enable) :
                   addr == ADDR_MODE        ? 32'(mode) :
                   state == IDLE            ? 32'(claim_id) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            enable         <= '0;
            mode           <= '0;
            cur_id         <= '0;
            bus.ext_irq    <= 1'b0;
            bus.reg_rdata  <= '0;
            bus.reg_rvalid <= 1'b0;
        end else begin
            state          <= state_nx;
            cur_id         <= claim_fire ? claim_id : cur_id;
            enable         <= (bus.reg_wen && addr == ADDR_ENABLE) ? bus.reg_wdata[N_SRC-1:0] : enable;
            mode           <= (bus.reg_wen && addr == ADDR_MODE) ? bus.reg_wdata[N_SRC-1:0] : mode;
            bus.ext_irq    <= state == IDLE && |req;
            bus.reg_rvalid <= bus.reg_ren;
            bus.reg_rdata  <= bus.reg_ren ? rdata_nx : bus.reg_rdata;
        end
    end

endmodule

// File: tb/tb_wdt_irq_ctrl.sv
// tb_wdt_irq_ctrl: randomized and scripted stimulus scored against a behavioural controller model
module tb_wdt_irq_ctrl;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] src_irq;
    logic [1:0] src_v = 2'b00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    rd_t        q[$];
    rd_t        mon_e;

    logic [1:0] m_pend = '0, m_infl = '0, m_en = '0, m_md = '0, m_prev = '0;
    logic       m_busy = 1'b0;
    logic       m_ext = 1'b0;
    int         m_cid = 0;

    wdt_irq_ctrl_if bus ();

    wdt_irq_ctrl #(.N_SRC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .src_irq (src_irq),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lowest(input logic [1:0] r);
        for (int i = 0; i < 2; i++)
            if (r[i]) return i + 1;
        return 0;
    endfunction

    task automatic step(input logic r, input logic w, input logic rn, input logic [1:0] a, input logic [31:0] d);
        int          lo;
        logic [1:0]  np, ni, ne, nm;
        logic        nb, nx, cl, co, set;
        int          nc;
        logic [31:0] exp_d;
        rst           = r;
        bus.reg_wen   = w;
        bus.reg_ren   = rn;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        src_irq       = src_v;
        lo = lowest(m_pend & m_en);
        cl = rn && !w && a == 2'd2 && !m_busy && lo != 0;
        co = w && a == 2'd2 && m_busy && int'(d[1:0]) == m_cid;
        if (w) exp_d = 0;
        else if (a == 2'd0) exp_d = 32'(m_pend);
        else if (a == 2'd1) exp_d = 32'(m_en);
        else if (a == 2'd3) exp_d = 32'(m_md);
        else exp_d = m_busy ? 0 : lo;
        if (r && rn) q.push_back('{data: exp_d, due: cyc + 1});
        nx = !m_busy && (m_pend & m_en) != 2'b00;
        np = m_pend;
        ni = m_infl;
        for (int i = 0; i < 2; i++) begin
            set = !m_infl[i] && (m_md[i] ? (src_v[i] && !m_prev[i]) : src_v[i]);
            if (cl && lo == i + 1) begin
                np[i] = 1'b0;
                ni[i] = 1'b1;
            end else if (set) np[i] = 1'b1;
            if (co && m_cid == i + 1) ni[i] = 1'b0;
        end
        ne = (w && a == 2'd1) ? d[1:0] : m_en;
        nm = (w && a == 2'd3) ? d[1:0] : m_md;
        nb = cl ? 1'b1 : co ? 1'b0 : m_busy;
        nc = cl ? lo : m_cid;
        @(posedge clk);
        if (!r) begin
            m_pend = 0; m_infl = 0; m_en = 0; m_md = 0; m_prev = 0;
            m_busy = 0; m_cid = 0; m_ext = 0;
        end else begin
            m_pend = np; m_infl = ni; m_en = ne; m_md = nm; m_prev = src_v;
            m_busy = nb; m_cid = nc; m_ext = nx;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b1, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic reset_cyc(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        checks++;
        if (bus.ext_irq !== m_ext) begin
            errors++;
            $display("FAIL ext_irq cyc=%0d got=%b exp=%b", cyc, bus.ext_irq, m_ext);
        end
        if (bus.reg_rvalid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_spurious cyc=%0d got=1 exp=0", cyc);
            end else begin
                mon_e = q.pop_front();
                if (bus.reg_rdata !== mon_e.data || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL reg_rdata cyc=%0d got=%h exp=%h due=%0d", cyc, bus.reg_rdata, mon_e.data, mon_e.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            checks++;
            errors++;
            mon_e = q.pop_front();
            $display("FAIL rvalid_missing cyc=%0d got=%b exp=1", cyc, bus.reg_rvalid);
        end
    end

    initial begin
        reset_cyc(2);
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        wr(2'd1, 32'd1);
        src_v = 2'b01;
        idle(3);
        rd(2'd0);
        rd(2'd2);
        idle(2);
        rd(2'd2);
        wr(2'd2, 32'd1);
        idle(3);
        rd(2'd2);
        src_v = 2'b00;
        wr(2'd2, 32'd1);
        idle(2);
        wr(2'd1, 32'hFFFF_FFFF);
        src_v = 2'b11;
        idle(3);
        rd(2'd2);
        idle(1);
        rd(2'd2);
        wr(2'd2, 32'd2);
        idle(2);
        wr(2'd2, 32'd1);
        idle(3);
        rd(2'd2);
        src_v = 2'b00;
        wr(2'd2, 32'd2);
        idle(3);
        reset_cyc(1);
        wr(2'd3, 32'd2);
        wr(2'd1, 32'd2);
        rd(2'd3);
        src_v = 2'b10; idle(1);
        src_v = 2'b00; idle(2);
        rd(2'd2);
        src_v = 2'b10; idle(1);
        src_v = 2'b00; idle(1);
        src_v = 2'b10; idle(1);
        src_v = 2'b00; idle(1);
        wr(2'd2, 32'd2);
        idle(3);
        rd(2'd0);
        wr(2'd3, 32'd0);
        src_v = 2'b10;
        idle(2);
        rd(2'd2);
        idle(1);
        reset_cyc(1);
        rd(2'd0); rd(2'd1); rd(2'd3);
        idle(3);
        rd(2'd0);
        step(1'b1, 1'b1, 1'b1, 2'd1, 32'd3);
        rd(2'd1);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 2'd2, 32'd2);
        idle(2);
        for (int n = 0; n < 3000; n++) begin
            int op;
            logic [1:0] a;
            if ($urandom_range(0, 3) == 0) src_v = 2'($urandom);
            a = 2'($urandom);
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 199) == 0) reset_cyc(1);
            else if (op < 3) idle(1);
            else if (op < 6) rd(a);
            else if (op < 9) wr(a, a == 2'd2 ? 32'($urandom_range(0, 3)) : $urandom);
            else step(1'b1, 1'b1, 1'b1, a, $urandom);
        end
        idle(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL read_queue_drain got=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wdt_irq_ctrl.md
Name: wdt_irq_ctrl

Overview:
CPU-domain interrupt gateway and controller that consumes the synchronized watchdog timeout level (WTO_interrupt) and other peripheral interrupt lines. It latches requests into pending bits and masks them with enable bits. It arbitrates by fixed priority and presents one registered external-interrupt level to the CPU, with a claim/complete handshake over a small register port. Source 1 is wired to WTO_interrupt; source 2 is the DMA interrupt.

Parameters:
N_SRC, 2, number of interrupt sources (1..31); IDs are 1..N_SRC, and ID 0 means "none"
ID_W, $clog2(N_SRC+1), width of claim/complete ID (derived, not overridden)

Ports:
clk  input  1  single clock (CPU domain)
rst  input  1  synchronous, active-low reset
src_irq  input  N_SRC  interrupt levels, already synchronized to clk; bit i-1 is source ID i
reg_wen  input  1  register write strobe, one cycle
reg_ren  input  1  register read strobe, one cycle
reg_addr  input  2  word select: 0 PENDING (RO), 1 ENABLE (RW), 2 CLAIM/COMPLETE, 3 MODE (RW; 1=edge, 0=level)
reg_wdata  input  32  write data
reg_rdata  output  32  read data, valid with reg_rvalid
reg_rvalid  output  1  one-cycle pulse, exactly one cycle after reg_ren
ext_irq  output  1  registered interrupt request to CPU

Behaviour:
- Reset (rst low at posedge): pending, enable, mode, in_flight, src_q = 0; state IDLE; ext_irq = 0, reg_rdata = 0, reg_rvalid = 0.
- Edge detect: src_q <= src_irq every cycle. An edge event is src_irq[i] & ~src_q[i].
- Gateway set condition for source i, when in_flight[i] = 0:
  - level mode: src_irq[i] = 1 sets pending[i];
  - edge mode: edge event sets pending[i].
  - While in_flight[i] = 1, set conditions are ignored; edges arriving then are dropped.
- Pending latency: pending[i] updates at the posedge where the set condition is sampled. ext_irq <= (state == IDLE) && |(pending & enable), so ext_irq rises one cycle after pending.
- Disabling a source does not clear its pending bit; re-enabling re-asserts ext_irq.
- FSM states:
  - IDLE: a CLAIM read returns the lowest-numbered ID with pending & enable set.
    - If the ID is non-zero: clear pending[ID], set in_flight[ID], go to BUSY.
    - If zero: return 0 and stay in IDLE.
  - BUSY: a CLAIM read returns 0 with no state change. ext_irq is forced low (deasserts the cycle after the claim).
  - BUSY: a write to CLAIM/COMPLETE with reg_wdata[ID_W-1:0] equal to the claimed ID clears in_flight and returns to IDLE.
    - Any other ID, or 0, is ignored and the state stays BUSY.
  - IDLE: writes to CLAIM/COMPLETE are ignored.
- Level source still high after complete: pending re-sets on the next cycle and ext_irq re-asserts one cycle later. This is the required WDT re-fire behaviour.
- Simultaneous set condition and claim of the same source: the claim wins. pending ends at 0 and in_flight at 1.
- reg_wen and reg_ren in the same cycle: the write executes, the read has no side effects, and reg_rdata = 0 with reg_rvalid still pulsing.
- Reads of ENABLE, MODE and PENDING return register values in bits [N_SRC-1:0], with upper bits 0. Reads return the pre-update value for that cycle.
- Writes to PENDING are ignored. Write bits at N_SRC and above are discarded.
- Reset mid-BUSY: everything returns to reset values and the outstanding claim is abandoned.

Decomposition:
- Package wdt_irq_pkg holds:
  - the register address enum (ADDR_PENDING = 0, ADDR_ENABLE = 1, ADDR_CLAIM = 2, ADDR_MODE = 3);
  - the state_t enum (IDLE, BUSY);
  - the source ID constants SRC_WDT = 1, SRC_DMA = 2.
- One sub-module: irq_gateway, instantiated per source. It contains the edge detect, mode select, pending and in_flight bits, with claim and complete strobes as inputs.
- Priority encoder, FSM and register port stay in the top level.

Test Plan:
- Reset, then enable = 2'b01 and src_irq[0] rises at cycle t -> PENDING reads 2'b01, ext_irq = 1 at t+2, reg_rdata = 0 for every register read before this.
- Both sources pending with enable = 2'b11 -> CLAIM read returns 1 with rvalid one cycle after ren; ext_irq = 0 next cycle; a second CLAIM read returns 0.
- Level source 1 held high, claimed, then complete written with wdata = 1 -> state IDLE, pending[0] re-sets next cycle, ext_irq re-asserts.
- Edge mode (MODE = 2'b10), two pulses on src_irq[1] while ID 2 is in flight -> only the first is serviced; after complete, PENDING = 0 and ext_irq stays 0.
- Complete with wrong ID (wdata = 2 while ID 1 claimed) -> ignored: ext_irq stays 0; a subsequent complete with 1 restores IDLE.
- rst low while BUSY with pending = 2'b10 -> all registers 0, ext_irq = 0, rvalid = 0; after release, src_irq[1] high with ENABLE = 0 gives no ext_irq.
